iir_sos_sched: RTL
==================

Name: iir_sos_sched

Overview:
- Time-multiplexed scheduler for the IIR section cascade. A single shared second-order-section engine replaces seven dedicated stage instances.
- Accepts 12-bit input samples and scales each to 18 bits ({din, 6'b0}).
- Issues the sample through sections 0..NSEC-1 on the shared engine, chaining each section's output into the next, then presents the final result with a one-cycle valid.
- Sits between the sample source and the shared engine. Also provides input buffering, overrun detection and an engine watchdog.

Parameters:
- NSEC, 7, number of cascaded sections sequenced per sample (1..15)
- DIN_W, 12, input sample width
- DW, 18, internal/output data width; input is left-shifted by DW-DIN_W
- TIMEOUT, 255, max WAIT cycles for sec_done before abort (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- din  in  DIN_W  signed input sample
- din_valid  in  1  din qualifier, one sample per high cycle
- ovr_clr  in  1  clears sticky overrun/timeout flags
- sec_idx  out  4  section index presented to engine (selects coefficients and state)
- sec_start  out  1  one-cycle start strobe to engine
- sec_din  out  DW  signed engine input
- sec_done  in  1  engine result valid, one cycle
- sec_dout  in  DW  signed engine result, valid with sec_done
- dout  out  DW  signed filtered output
- dout_valid  out  1  dout qualifier, one cycle per sample
- dout_prevalid  out  1  one-cycle pulse when section 0 result is captured
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: sample dropped
- timeout_err  out  1  sticky: engine watchdog fired

Behaviour:
- Reset (rst=0, async) clears all outputs and internal state:
  - state=IDLE; hold register empty; section counter k=0
  - sec_start, dout_valid, dout_prevalid, overrun and timeout_err = 0
  - dout, sec_din = 0; sec_idx = 0
- Reset mid-sequence aborts the sample; the engine is not notified.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - din_valid=1: cur <= {din, 6'b0}, k <= 0, go to ISSUE.
  - Hold register full: take the hold sample instead.
- ISSUE:
  - Lasts exactly one cycle. Drives sec_start=1, sec_idx=k, sec_din=cur.
  - Clears the watchdog counter; goes to WAIT.
- WAIT:
  - sec_start=0 and sec_idx held.
  - On sec_done: cur <= sec_dout. If k==0, pulse dout_prevalid next cycle. If k==NSEC-1, go to OUT; else k <= k+1 and go to ISSUE.
  - Watchdog: counts WAIT cycles. If it reaches TIMEOUT with no sec_done: set timeout_err, discard the sample, no dout_valid, go to IDLE.
- OUT:
  - dout <= cur is loaded on entry; dout_valid=1 for this single cycle.
  - Next state: ISSUE with the hold sample if hold is full, else IDLE.
- dout holds its last value between valids.
- Latency, with engine latency L (sec_done L≥1 cycles after sec_start):
  - din_valid sampled in cycle c, ISSUE in cycle c+1.
  - Each section takes L+1 cycles.
  - dout_valid in cycle c+1+NSEC*(L+1); NSEC=7, L=1 gives c+15.
- Input buffering:
  - din_valid while busy and hold empty: sample captured into hold.
  - din_valid while busy and hold full: sample dropped, overrun set. The hold contents are kept.
  - din_valid in the same cycle the hold is consumed (OUT→ISSUE): new sample enters hold, no overrun.
- Ignored inputs:
  - sec_done outside WAIT is ignored.
  - sec_dout is sampled only with sec_done.
- Flags:
  - ovr_clr clears overrun and timeout_err.
  - A set event in the same cycle as ovr_clr wins (flag stays 1).
- Arithmetic: no saturation inside the scheduler; sign is preserved through the shift.

Decomposition:
- Shared package (iir_pkg):
  - DIN_W/DW constants
  - state enum {IDLE, ISSUE, WAIT, OUT}
  - section index width
  - input scaling shift (6)
- Optional sub-module iir_sched_hold: one-entry skid/hold register with full flag and overrun detection.
- The FSM, counter and watchdog stay in the top.

Test Plan:
- Single sample, L=1 engine model (sec_dout = sec_din + k+1), din=12'sd5 at cycle 0:
  - sec_start pulses in cycles 1,3,..,13 with sec_idx 0..6.
  - dout_valid in cycle 15, dout = 320+28 = 348.
  - dout_prevalid one pulse.
- Negative input din=-1: sec_din in first ISSUE = 18'h3FFC0; sign is preserved through all sections.
- Back-to-back din_valid in cycles 0,1,2:
  - Sample 1 runs, sample 2 is held, sample 3 is dropped with overrun=1.
  - Sample 2 dout_valid in cycle 30 (OUT→ISSUE directly).
  - ovr_clr clears overrun.
- Engine never asserts sec_done, TIMEOUT=8:
  - timeout_err=1 after 8 WAIT cycles; no dout_valid.
  - busy returns to 0; the next sample completes normally.
- rst pulsed low mid-WAIT at section 3:
  - All outputs are 0 immediately (async).
  - A stale sec_done after release is ignored; a new sample completes normally.
- Spurious sec_done in IDLE, and ovr_clr coincident with a new overrun: state unchanged by the sec_done; overrun stays 1.

Source files
------------

// File: rtl/iir_sos_sched_pkg.sv
// Shared types and constants for the time-multiplexed IIR second-order-section scheduler.
package iir_sos_sched_pkg;
  localparam int DIN_W_DEF = 12;
  localparam int IN_SHIFT  = 6;
  localparam int DW_DEF    = DIN_W_DEF + IN_SHIFT;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;
endpackage

// File: rtl/iir_sos_sched_hold.sv
// One-entry skid register for samples arriving while the scheduler is busy, with sticky overrun.
module iir_sos_sched_hold #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  input  logic [DW-1:0] i_din,
  output logic          o_full,
  output logic [DW-1:0] o_data,
  output logic          o_ovr
);
  logic          r_full;
  logic [DW-1:0] r_data;
  logic          r_ovr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_ovr  <= 1'b0;
    end else begin
      // A pop frees the slot in the same cycle, so a coincident push refills it.
      if (i_pop) begin
        r_full <= i_push;
        if (i_push) r_data <= i_din;
      end else if (i_push && !r_full) begin
        r_full <= 1'b1;
        r_data <= i_din;
      end
      r_ovr <= (i_push && r_full && !i_pop) || (r_ovr && !i_clr);
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_ovr  = r_ovr;
endmodule

// File: rtl/iir_sos_sched.sv
// Sequences each input sample through NSEC sections on one shared SOS engine, chaining results.
module iir_sos_sched
  import iir_sos_sched_pkg::*;
#(
  parameter int NSEC    = 7,
  parameter int DIN_W   = DIN_W_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  input  logic             ovr_clr,
  output logic [IDX_W-1:0] sec_idx,
  output logic             sec_start,
  output logic [DW-1:0]    sec_din,
  input  logic             sec_done,
  input  logic [DW-1:0]    sec_dout,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  output logic             dout_prevalid,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(NSEC - 1);
  localparam logic [7:0]       WD_LAST = 8'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_k;
  logic [DW-1:0]    r_cur, r_dout, w_scaled, w_hold_data;
  logic [7:0]       r_wd;
  logic             r_prev, r_tmo;
  logic             w_idle, w_hold_full, w_pop, w_push, w_direct, w_last, w_tmo_evt, w_ovr;

  assign w_scaled  = {din, {(DW-DIN_W){1'b0}}};
  assign w_idle    = (r_state == S_IDLE);
  assign w_last    = (r_k == K_LAST);
  assign w_tmo_evt = (r_state == S_WAIT) && !sec_done && (r_wd == WD_LAST);
  // Held sample is restarted from IDLE (after an abort) or straight out of OUT.
  assign w_pop     = w_hold_full && (w_idle || r_state == S_OUT);
  assign w_direct  = din_valid && w_idle && !w_hold_full;
  assign w_push    = din_valid && !w_direct;

  iir_sos_sched_hold #(.DW(DW)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clr  (ovr_clr),
    .i_din  (w_scaled),
    .o_full (w_hold_full),
    .o_data (w_hold_data),
    .o_ovr  (w_ovr)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hold_full || din_valid) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (sec_done)       w_state_nxt = w_last ? S_OUT : S_ISSUE;
        else if (w_tmo_evt) w_state_nxt = S_IDLE;
      end
      S_OUT:   w_state_nxt = w_hold_full ? S_ISSUE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cur   <= '0;
      r_dout  <= '0;
      r_wd    <= '0;
      r_prev  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_hold_full) begin
            r_cur <= w_hold_data;
            r_k   <= '0;
          end else if (din_valid) begin
            r_cur <= w_scaled;
            r_k   <= '0;
          end
        end
        S_ISSUE: r_wd <= '0;
        S_WAIT: begin
          if (sec_done) begin
            r_cur <= sec_dout;
            if (w_last) r_dout <= sec_dout;
            else        r_k    <= r_k + 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_OUT: begin
          if (w_hold_full) begin
            r_cur <= w_hold_data;
            r_k   <= '0;
          end
        end
        default: ;
      endcase
      r_prev <= (r_state == S_WAIT) && sec_done && (r_k == '0);
      r_tmo  <= w_tmo_evt || (r_tmo && !ovr_clr);
    end
  end

  assign sec_idx       = r_k;
  assign sec_start     = (r_state == S_ISSUE);
  assign sec_din       = r_cur;
  assign dout          = r_dout;
  assign dout_valid    = (r_state == S_OUT);
  assign dout_prevalid = r_prev;
  assign busy          = !w_idle;
  assign overrun       = w_ovr;
  assign timeout_err   = r_tmo;
endmodule
